// File: rtl/replay_buffer_ctrl_if.sv
// Signal bundle between the frame source / serializer / link partner and the replay buffer.
// The master modport is the environment side; the slave modport is the buffer itself.
interface replay_buffer_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic [ADDR_WIDTH-1:0] o_seq;
  logic                  o_valid;
  logic                  i_ready;
  logic                  i_ack;
  logic                  i_nack;
  logic [ADDR_WIDTH-1:0] i_ack_seq;
  logic                  o_replay;
  logic                  o_full;
  logic                  o_empty;
  logic [ADDR_WIDTH:0]   o_count;

  modport master (
    output i_data, i_valid, i_ready, i_ack, i_nack, i_ack_seq,
    input  o_ready, o_data, o_seq, o_valid, o_replay, o_full, o_empty, o_count
  );

  modport slave (
    input  i_data, i_valid, i_ready, i_ack, i_nack, i_ack_seq,
    output o_ready, o_data, o_seq, o_valid, o_replay, o_full, o_empty, o_count
  );
endinterface

// File: rtl/replay_buffer_ctrl.sv
// TX-path retransmit buffer: stores accepted words, forwards them with sequence numbers,
// and rewinds to the oldest unacknowledged word on NACK or ACK timeout.
module replay_buffer_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 3,
  parameter int REPLAY_TIMEOUT = 256
) (
  input logic                 i_clk,
  input logic                 i_rst,
  replay_buffer_ctrl_if.slave bus
);
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int TMO_W = $clog2(REPLAY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr, ack_ptr;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  rewind_pending;
  logic                  valid_q, replay_q, full_q, empty_q;
  logic [PTR_W-1:0]      count_q;

  logic                  ready, wr_en, handshake, ack_valid, nack_valid;
  logic                  tmo_hit, rewind_req, rewind_apply, move;
  logic [ADDR_WIDTH-1:0] off;
  logic [PTR_W-1:0]      sent, wr_next, ack_next, rd_target, count_next;

  assign ready = ~full_q & ~i_rst;

  always_comb begin
    wr_en      = bus.i_valid & ready;
    handshake  = (state == SEND) & bus.i_ready;
    off        = bus.i_ack_seq - ack_ptr[ADDR_WIDTH-1:0];
    sent       = rd_ptr - ack_ptr;
    nack_valid = bus.i_nack & ({1'b0, off} <= sent);
    ack_valid  = bus.i_ack & ~bus.i_nack & ({1'b0, off} < sent);
    ack_next   = ack_ptr;
    if (ack_valid)
      ack_next = ack_ptr + {1'b0, off} + PTR_W'(1);
    else if (nack_valid)
      ack_next = ack_ptr + {1'b0, off};
    wr_next    = wr_ptr + PTR_W'(wr_en);
    count_next = wr_next - ack_next;
    tmo_hit    = (sent != '0) & ~ack_valid & ~nack_valid &
                 (tmo_cnt == TMO_W'(REPLAY_TIMEOUT - 1));
    rewind_req = nack_valid | tmo_hit;
    // A rewind requested mid-SEND waits for the handshake so the presented word never changes under the serializer.
    rewind_apply = (state == SEND) ? (handshake & (rewind_pending | rewind_req)) : rewind_req;
    move       = rewind_apply | handshake;
    rd_target  = rewind_apply ? ack_next : rd_ptr + PTR_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.i_data;
    rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      ack_ptr        <= '0;
      tmo_cnt        <= '0;
      rewind_pending <= 1'b0;
      valid_q        <= 1'b0;
      replay_q       <= 1'b0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      count_q        <= '0;
    end else begin
      wr_ptr   <= wr_next;
      ack_ptr  <= ack_next;
      replay_q <= rewind_apply;
      count_q  <= count_next;
      full_q   <= count_next == PTR_W'(DEPTH);
      empty_q  <= count_next == '0;
      if (ack_valid | nack_valid | rewind_apply | tmo_hit | (sent == '0))
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (move) begin
        rd_ptr         <= rd_target;
        valid_q        <= 1'b0;
        rewind_pending <= 1'b0;
        state          <= (rd_target != wr_next) ? FETCH : IDLE;
      end else begin
        case (state)
          IDLE:    if (rd_ptr != wr_ptr) state <= FETCH;
          FETCH: begin
            state   <= SEND;
            valid_q <= 1'b1;
          end
          SEND:    if (rewind_req) rewind_pending <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_ready  = ready;
  assign bus.o_data   = rd_data;
  assign bus.o_seq    = rd_ptr[ADDR_WIDTH-1:0];
  assign bus.o_valid  = valid_q;
  assign bus.o_replay = replay_q;
  assign bus.o_full   = full_q;
  assign bus.o_empty  = empty_q;
  assign bus.o_count  = count_q;
endmodule

// File: tb/tb_replay_buffer_ctrl.sv
// Bench for replay_buffer_ctrl: directed scenarios with literal expectations, then random
// traffic checked every cycle against a word-level model of the retransmit window.
module tb_replay_buffer_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int RT    = 16;
  localparam int DEPTH = 1 << AW;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  bit   chk_en      = 1'b0;

  replay_buffer_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  replay_buffer_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REPLAY_TIMEOUT(RT)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus(bus)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Word-level model: unbounded absolute pointers into the list of every word ever accepted.
  int            m_wr, m_rd, m_ack, m_tmo;
  bit            m_pending, m_fetching, m_presenting, m_replay;
  logic [DW-1:0] stored[$];

  always @(posedge i_clk) begin : model
    int sent, off, new_ack, new_wr;
    bit hs, wr_en, nv, av, tmo, rew, apply;
    if (i_rst) begin
      m_wr = 0; m_rd = 0; m_ack = 0; m_tmo = 0;
      m_pending = 0; m_fetching = 0; m_presenting = 0; m_replay = 0;
      stored.delete();
    end else begin
      sent    = m_rd - m_ack;
      off     = ((int'(bus.i_ack_seq) - m_ack) % DEPTH + DEPTH) % DEPTH;
      hs      = m_presenting && bus.i_ready;
      wr_en   = bus.i_valid && (m_wr - m_ack < DEPTH);
      nv      = bus.i_nack && (off <= sent);
      av      = bus.i_ack && !bus.i_nack && (off < sent);
      new_ack = m_ack + (av ? off + 1 : (nv ? off : 0));
      tmo     = (sent != 0) && !av && !nv && (m_tmo == RT - 1);
      rew     = nv || tmo;
      apply   = m_presenting ? (hs && (m_pending || rew)) : rew;
      new_wr  = m_wr + (wr_en ? 1 : 0);
      if (wr_en) stored.push_back(bus.i_data);
      m_tmo = (av || nv || apply || tmo || sent == 0) ? 0 : m_tmo + 1;
      if (m_presenting && !hs) begin
        if (rew) m_pending = 1;
      end else if (hs || apply) begin
        m_rd         = apply ? new_ack : m_rd + 1;
        m_presenting = 0;
        m_pending    = 0;
        m_fetching   = (m_rd != new_wr);
      end else if (m_fetching) begin
        m_fetching   = 0;
        m_presenting = 1;
      end else begin
        m_fetching = (m_rd != m_wr);
      end
      m_replay = apply;
      m_ack    = new_ack;
      m_wr     = new_wr;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge i_clk) begin
    if (chk_en) begin
      checkOutput("o_ready", 32'(bus.o_ready), 32'((m_wr - m_ack != DEPTH) && !i_rst));
      checkOutput("o_full", 32'(bus.o_full), 32'(m_wr - m_ack == DEPTH));
      checkOutput("o_empty", 32'(bus.o_empty), 32'(m_wr == m_ack));
      checkOutput("o_count", 32'(bus.o_count), 32'(m_wr - m_ack));
      checkOutput("o_valid", 32'(bus.o_valid), 32'(m_presenting));
      checkOutput("o_replay", 32'(bus.o_replay), 32'(m_replay));
      if (m_presenting) begin
        checkOutput("o_data", 32'(bus.o_data), 32'(stored[m_rd]));
        checkOutput("o_seq", 32'(bus.o_seq), 32'(m_rd % DEPTH));
      end
    end
  end

  task automatic applyStimulus(input logic valid, input logic [DW-1:0] data, input logic ready,
                               input logic ack, input logic nack, input logic [AW-1:0] seq);
    bus.i_valid   = valid;
    bus.i_data    = data;
    bus.i_ready   = ready;
    bus.i_ack     = ack;
    bus.i_nack    = nack;
    bus.i_ack_seq = seq;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic doReset();
    i_rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    step();
    i_rst = 1'b0;
    step();
  endtask

  task automatic waitValid();
    int waited = 0;
    while (bus.o_valid !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    checkOutput("wait_valid", 32'(bus.o_valid), 32'd1);
  endtask

  task automatic sendOne(input logic [DW-1:0] expData, input int expSeq, output int hsCycle);
    bus.i_ready = 1'b0;
    waitValid();
    checkOutput("send_data", 32'(bus.o_data), 32'(expData));
    checkOutput("send_seq", 32'(bus.o_seq), 32'(expSeq));
    bus.i_ready = 1'b1;
    step();
    hsCycle = cyc;
    bus.i_ready = 1'b0;
  endtask

  initial begin
    int h0, h;
    int waited;
    logic [AW-1:0] aseq;

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    i_rst = 1'b1;
    step();
    step();
    checkOutput("t1_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("t1_ready", 32'(bus.o_ready), 32'd0);
    checkOutput("t1_empty", 32'(bus.o_empty), 32'd1);
    chk_en = 1'b1;
    i_rst  = 1'b0;
    step();
    checkOutput("t1_ready_rel", 32'(bus.o_ready), 32'd1);
    checkOutput("t1_count", 32'(bus.o_count), 32'd0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0, 1'b0, 3'd0);
      step();
      if (i < 2) checkOutput("t2_latency", 32'(bus.o_valid), 32'd0);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t2_valid", 32'(bus.o_valid), 32'd1);
      checkOutput("t2_data", 32'(bus.o_data), 32'hA0 + 32'(i));
      checkOutput("t2_seq", 32'(bus.o_seq), 32'(i));
      step();
      checkOutput("t2_gap", 32'(bus.o_valid), 32'd0);
      step();
    end

    checkOutput("t3_count_pre", 32'(bus.o_count), 32'd3);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1);
    step();
    checkOutput("t3_count_ack", 32'(bus.o_count), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd5);
    step();
    checkOutput("t3_count_ign", 32'(bus.o_count), 32'd1);

    doReset();
    for (int i = 0; i < 8; i++) begin
      checkOutput("t4_ready_fill", 32'(bus.o_ready), 32'd1);
      applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, 3'd0);
      step();
    end
    checkOutput("t4_full", 32'(bus.o_full), 32'd1);
    checkOutput("t4_ready_full", 32'(bus.o_ready), 32'd0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    checkOutput("t4_count_held", 32'(bus.o_count), 32'd8);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    sendOne(8'h10, 0, h);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    checkOutput("t4_full_clr", 32'(bus.o_full), 32'd0);
    checkOutput("t4_ready_back", 32'(bus.o_ready), 32'd1);
    checkOutput("t4_count", 32'(bus.o_count), 32'd7);

    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0, 3'd0);
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) sendOne(8'h50 + 8'(i), i, h);
    waitValid();
    checkOutput("t5_seq3", 32'(bus.o_seq), 32'd3);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    step();
    checkOutput("t5_held_valid", 32'(bus.o_valid), 32'd1);
    checkOutput("t5_held_data", 32'(bus.o_data), 32'h53);
    checkOutput("t5_no_replay", 32'(bus.o_replay), 32'd0);
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    checkOutput("t5_replay", 32'(bus.o_replay), 32'd1);
    for (int i = 1; i < 4; i++) sendOne(8'h50 + 8'(i), i, h);
    checkOutput("t5_count", 32'(bus.o_count), 32'd3);

    doReset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0, 3'd0);
      step();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    sendOne(8'h60, 0, h0);
    sendOne(8'h61, 1, h);
    waited = 0;
    while (bus.o_replay !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    checkOutput("t6_replay", 32'(bus.o_replay), 32'd1);
    checkOutput("t6_delay", 32'(cyc - h0), 32'd16);
    sendOne(8'h60, 0, h);
    sendOne(8'h61, 1, h);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd1);
    step();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    checkOutput("t6_empty", 32'(bus.o_empty), 32'd1);
    checkOutput("t6_count", 32'(bus.o_count), 32'd0);

    doReset();
    for (int n = 0; n < 3000; n++) begin
      aseq = AW'(m_ack + int'($urandom_range(0, 5)));
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 9) < 6),
                    1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 24) == 0), aseq);
      i_rst = ($urandom_range(0, 299) == 0);
      step();
    end
    i_rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
